universal_shift_register_n: RTL and testbench

UNIVERSAL_SHIFT_REGISTER_N -- requirements
Module: universal_shift_register_n

---
 rtl/usr_pkg.sv | 26 ++
 rtl/usr_step_unit.sv | 56 +++++
 rtl/universal_shift_register_n.sv | 112 +++++++++++
 tb/tb_universal_shift_register_n.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - mode codes, FSM states and helpers for the universal shift register
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROTR  = 3'b100,
    MODE_ROTL  = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Only these modes are worth repeating; hold/load/clear are idempotent.
  function automatic logic is_shift_mode(input mode_e m);
    return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROTR) ||
           (m == MODE_ROTL) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/usr_step_unit.sv
// rtl/usr_step_unit.sv - single-step next-value logic shared by the IDLE and RUN paths
module usr_step_unit
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value_i,
  input  mode_e            mode_i,
  input  logic             sri_i,
  input  logic             sli_i,
  output logic [WIDTH-1:0] next_o,
  output logic             out_bit_o,
  output logic             out_en_o
);

  // Load passes the value through; the top substitutes the parallel data.
  always_comb begin
    next_o    = value_i;
    out_bit_o = 1'b0;
    out_en_o  = 1'b0;
    case (mode_i)
      MODE_HOLD, MODE_LOAD: begin
        next_o = value_i;
      end
      MODE_SHR: begin
        next_o    = {sri_i, value_i[WIDTH-1:1]};
        out_bit_o = value_i[0];
        out_en_o  = 1'b1;
      end
      MODE_SHL: begin
        next_o    = {value_i[WIDTH-2:0], sli_i};
        out_bit_o = value_i[WIDTH-1];
        out_en_o  = 1'b1;
      end
      MODE_ROTR: begin
        next_o    = {value_i[0], value_i[WIDTH-1:1]};
        out_bit_o = value_i[0];
        out_en_o  = 1'b1;
      end
      MODE_ROTL: begin
        next_o    = {value_i[WIDTH-2:0], value_i[WIDTH-1]};
        out_bit_o = value_i[WIDTH-1];
        out_en_o  = 1'b1;
      end
      MODE_ASR: begin
        next_o    = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
        out_bit_o = value_i[0];
        out_en_o  = 1'b1;
      end
      MODE_CLEAR: begin
        next_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/universal_shift_register_n.sv
// rtl/universal_shift_register_n.sv - universal shift register with multi-step RUN sequencer
module universal_shift_register_n
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sri,
  input  logic             sli,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] dout,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  mode_e            run_mode_q, run_mode_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  mode_e            live_mode;
  mode_e            step_mode;
  logic [WIDTH-1:0] step_next;
  logic             step_bit;
  logic             step_out_en;

  assign live_mode = mode_e'(mode);
  // In RUN the latched mode drives the step unit; the live mode is ignored.
  assign step_mode = (state_q == ST_RUN) ? run_mode_q : live_mode;

  usr_step_unit #(.WIDTH(WIDTH)) u_step (
    .value_i   (data_q),
    .mode_i    (step_mode),
    .sri_i     (sri),
    .sli_i     (sli),
    .next_o    (step_next),
    .out_bit_o (step_bit),
    .out_en_o  (step_out_en)
  );

  always_comb begin
    state_d    = state_q;
    run_mode_d = run_mode_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    sout_d     = sout_q;
    done_d     = 1'b0;
    if (enb) begin
      case (state_q)
        ST_IDLE: begin
          if (start && is_shift_mode(live_mode) && (amt != '0)) begin
            run_mode_d = live_mode;
            state_d    = ST_RUN;
            if (32'(amt) > 32'(WIDTH)) cnt_d = CNT_W'(WIDTH);
            else                       cnt_d = CNT_W'(amt);
          end else begin
            // A zero-length shift request only produces the completion pulse.
            if (!(start && is_shift_mode(live_mode))) begin
              data_d = (live_mode == MODE_LOAD) ? din : step_next;
              if (step_out_en) sout_d = step_bit;
            end
            done_d = start;
          end
        end
        ST_RUN: begin
          data_d = step_next;
          sout_d = step_bit;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      run_mode_q <= MODE_HOLD;
      data_q     <= '0;
      cnt_q      <= '0;
      sout_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_mode_q <= run_mode_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      sout_q     <= sout_d;
      done_q     <= done_d;
    end
  end

  assign dout = data_q;
  assign sout = sout_q;
  assign busy = (state_q == ST_RUN);
  assign done = done_q;

endmodule

// File: tb/tb_universal_shift_register_n.sv
// tb/tb_universal_shift_register_n.sv - scoreboard bench for universal_shift_register_n
module tb_universal_shift_register_n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] din = 8'h00;
  logic       sri = 1'b0;
  logic       sli = 1'b0;
  logic       start = 1'b0;
  logic [3:0] amt = 4'd0;
  logic [7:0] dout;
  logic       sout, busy, done;

  universal_shift_register_n #(.WIDTH(8), .AMT_W(4)) dut (
    .clk(clk), .rst(rst), .enb(enb), .mode(mode), .din(din), .sri(sri),
    .sli(sli), .start(start), .amt(amt), .dout(dout), .sout(sout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [7:0] dout;
    logic       sout;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  bit   drv_done = 1'b0;

  // Reference model: register value, last bit out, remaining steps of a run.
  logic [7:0] m_val = 8'h00;
  logic       m_sout = 1'b0;
  bit         m_run = 1'b0;
  int         m_rem = 0;
  logic [2:0] m_lm = 3'd0;
  logic       m_done = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic bit is_shift(input logic [2:0] m);
    return (m == 3'd1) || (m == 3'd2) || (m == 3'd4) || (m == 3'd5) || (m == 3'd6);
  endfunction

  task automatic m_step(input logic [2:0] m, input logic r_in, input logic l_in,
                        input logic [7:0] d);
    logic [7:0] v;
    v = m_val;
    case (m)
      3'd1: begin m_sout = v[0]; m_val = (v >> 1) | (r_in ? 8'h80 : 8'h00); end
      3'd2: begin m_sout = v[7]; m_val = (v << 1) | {7'd0, l_in}; end
      3'd3: m_val = d;
      3'd4: begin m_sout = v[0]; m_val = (v >> 1) | (v[0] ? 8'h80 : 8'h00); end
      3'd5: begin m_sout = v[7]; m_val = (v << 1) | {7'd0, v[7]}; end
      3'd6: begin m_sout = v[0]; m_val = (v >> 1) | (v & 8'h80); end
      3'd7: m_val = 8'h00;
      default: m_val = v;
    endcase
  endtask

  task automatic drive(input bit r, input bit e, input logic [2:0] m, input logic [7:0] d,
                       input bit rr, input bit ll, input bit s, input logic [3:0] a);
    exp_t x;
    rst = r; enb = e; mode = m; din = d; sri = rr; sli = ll; start = s; amt = a;
    if (r) begin
      m_val = 8'h00; m_sout = 1'b0; m_run = 1'b0; m_rem = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (e) begin
        if (m_run) begin
          m_step(m_lm, rr, ll, d);
          m_rem = m_rem - 1;
          if (m_rem == 0) begin m_run = 1'b0; m_done = 1'b1; end
        end else if (s && is_shift(m) && a != 4'd0) begin
          m_lm = m; m_run = 1'b1; m_rem = (a > 4'd8) ? 8 : int'(a);
        end else begin
          if (!(s && is_shift(m))) m_step(m, rr, ll, d);
          m_done = s;
        end
      end
    end
    x.tag = edge_cnt + 1; x.dout = m_val; x.sout = m_sout; x.busy = m_run; x.done = m_done;
    q.push_back(x);
    @(posedge clk); #1;
  endtask

  // Monitor: compares every expectation whose edge has already happened.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].tag <= edge_cnt) begin
        e = q.pop_front();
        checks++;
        if (dout !== e.dout || sout !== e.sout || busy !== e.busy || done !== e.done) begin
          errors++;
          $display("FAIL edge%0d: got dout=%h sout=%b busy=%b done=%b, want dout=%h sout=%b busy=%b done=%b",
                   e.tag, dout, sout, busy, done, e.dout, e.sout, e.busy, e.done);
        end
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    drive(1, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0);
    drive(1, 1, 3'd3, 8'hFF, 1, 1, 1, 4'd5);
    // load then shift right with sri=1
    drive(0, 1, 3'd3, 8'hA5, 0, 0, 0, 4'd0);
    drive(0, 1, 3'd1, 8'h00, 1, 0, 0, 4'd0);
    // asr x3 from 0x90
    drive(0, 1, 3'd3, 8'h90, 0, 0, 0, 4'd0);
    drive(0, 1, 3'd6, 8'h00, 0, 0, 1, 4'd3);
    for (int i = 0; i < 4; i++) drive(0, 1, 3'd0, 8'h00, 0, 0, 0, 4'd0);
    // rotl amt=12 saturates to 8
    drive(0, 1, 3'd3, 8'h3C, 0, 0, 0, 4'd0);
    drive(0, 1, 3'd5, 8'h00, 0, 0, 1, 4'd12);
    for (int i = 0; i < 9; i++) drive(0, 1, 3'd0, 8'h00, 0, 0, 0, 4'd0);
    // enb dropped mid-run; live mode/start ignored
    drive(0, 1, 3'd3, 8'h5A, 0, 0, 0, 4'd0);
    drive(0, 1, 3'd1, 8'h00, 0, 0, 1, 4'd4);
    drive(0, 1, 3'd7, 8'h00, 1, 0, 1, 4'd9);
    drive(0, 0, 3'd7, 8'h00, 1, 1, 1, 4'd9);
    drive(0, 0, 3'd3, 8'hFF, 1, 1, 1, 4'd9);
    for (int i = 0; i < 4; i++) drive(0, 1, 3'(i + 2), 8'hFF, 1, 0, 1, 4'd7);
    // reset aborts a run; zero-length start only pulses done
    drive(0, 1, 3'd4, 8'h00, 0, 0, 1, 4'd5);
    drive(0, 1, 3'd0, 8'h00, 0, 0, 0, 4'd0);
    drive(1, 1, 3'd0, 8'h00, 0, 0, 0, 4'd0);
    drive(0, 1, 3'd0, 8'h00, 0, 0, 0, 4'd0);
    drive(0, 1, 3'd3, 8'h77, 0, 0, 0, 4'd0);
    drive(0, 1, 3'd2, 8'h00, 0, 1, 1, 4'd0);
    drive(0, 1, 3'd0, 8'h00, 0, 0, 0, 4'd0);
    drive(0, 1, 3'd7, 8'h00, 0, 0, 1, 4'd3);
    drive(0, 1, 3'd0, 8'h00, 0, 0, 0, 4'd0);
    // randomized phase
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0), 3'($urandom),
            8'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
            4'($urandom));
    end
    drive(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0);
    drv_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!drv_done && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(posedge clk);
    checks++;
    if (!drv_done || q.size() != 0) begin
      errors++;
      $display("FAIL drain: driver_done=%0d pending=%0d, want driver_done=1 pending=0",
               drv_done, q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
